// File: rtl/db_read_addr_gen.sv
// -----------------------------------------------------------------------------
// db_read_addr_gen
//
// Read-address generator for a double-buffer read port. A start in IDLE
// captures a base address plus up to three (stride, range) loop dimensions.
// The block then walks the nested loop and emits one address per accepted
// handshake:
//
//   addr = starting_addr + c0*stride_0 + c1*stride_1 + c2*stride_2 (mod 2^16)
//
// c0 is the innermost counter. Addresses are built from per-dimension
// running offsets, so the datapath needs only adders.
//
// Ports
//   clk             rising-edge clock
//   reset           asynchronous, active-low reset
//   clk_en          global enable; low freezes every register
//   flush           synchronous abort back to IDLE (highest priority)
//   start           begin a pass (only honoured in IDLE)
//   dimensionality  number of active loop dimensions (0 -> 1, >3 -> 3)
//   starting_addr   base address of the pass
//   stride_0..2     per-dimension address step
//   range_0..2      per-dimension iteration count (0 is treated as 1)
//   addr_out        read address
//   addr_valid      addr_out is valid
//   addr_ready      consumer accepts addr_out
//   busy            a pass is in progress (state == RUN)
//   done            one-cycle pulse after the last address of a pass
//
// Build option
//   DB_AGEN_CIRCULAR_EN  when defined, the pass restarts from starting_addr
//                        after its last address and the block stays in RUN
//                        until flush or reset. Undefined by default.
// -----------------------------------------------------------------------------
module db_read_addr_gen #(
    parameter int DATA_W = 16,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clk_en,
    input  logic              flush,
    input  logic              start,
    input  logic [3:0]        dimensionality,
    input  logic [DATA_W-1:0] starting_addr,
    input  logic [DATA_W-1:0] stride_0,
    input  logic [DATA_W-1:0] stride_1,
    input  logic [DATA_W-1:0] stride_2,
    input  logic [CNT_W-1:0]  range_0,
    input  logic [CNT_W-1:0]  range_1,
    input  logic [CNT_W-1:0]  range_2,
    output logic [DATA_W-1:0] addr_out,
    output logic              addr_valid,
    input  logic              addr_ready,
    output logic              busy,
    output logic              done
);

    localparam int                NDIM      = 3;
    localparam logic [CNT_W-1:0]  CNT_ZERO  = '0;
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [DATA_W-1:0] ADDR_ZERO = '0;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    state_t            state_q, state_d;
    logic [DATA_W-1:0] base_q, base_d;
    logic [DATA_W-1:0] stride_q [NDIM];
    logic [DATA_W-1:0] stride_d [NDIM];
    logic [CNT_W-1:0]  last_q   [NDIM];   // effective range minus one
    logic [CNT_W-1:0]  last_d   [NDIM];
    logic [CNT_W-1:0]  cnt_q    [NDIM];
    logic [CNT_W-1:0]  cnt_d    [NDIM];
    logic [DATA_W-1:0] off_q    [NDIM];   // c_i * stride_i, kept incrementally
    logic [DATA_W-1:0] off_d    [NDIM];
    logic [DATA_W-1:0] addr_q, addr_d;
    logic              valid_q, valid_d;
    logic              done_q, done_d;

    // -------------------------------------------------------------------------
    // Configuration decode (applied only at the moment of capture)
    // -------------------------------------------------------------------------
    logic [DATA_W-1:0] stride_in  [NDIM];
    logic [CNT_W-1:0]  range_in   [NDIM];
    logic [DATA_W-1:0] cfg_stride [NDIM];
    logic [CNT_W-1:0]  cfg_last   [NDIM];
    logic [1:0]        dim_eff;

    assign stride_in[0] = stride_0;
    assign stride_in[1] = stride_1;
    assign stride_in[2] = stride_2;
    assign range_in[0]  = range_0;
    assign range_in[1]  = range_1;
    assign range_in[2]  = range_2;

    always_comb begin
        if (dimensionality == 4'd0) begin
            dim_eff = 2'd1;
        end else if (dimensionality > 4'd3) begin
            dim_eff = 2'd3;
        end else begin
            dim_eff = dimensionality[1:0];
        end

        // Inactive dimensions collapse to range 1 / stride 0, so the cascade
        // below can always run over all three counters.
        for (int i = 0; i < NDIM; i++) begin
            if (i < int'(dim_eff)) begin
                cfg_stride[i] = stride_in[i];
                cfg_last[i]   = (range_in[i] == CNT_ZERO) ? CNT_ZERO
                                                          : range_in[i] - CNT_ONE;
            end else begin
                cfg_stride[i] = ADDR_ZERO;
                cfg_last[i]   = CNT_ZERO;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Loop-nest status
    // -------------------------------------------------------------------------
    logic [NDIM-1:0] wrap;
    logic            hs;
    logic            pass_end;

    always_comb begin
        for (int i = 0; i < NDIM; i++) begin
            wrap[i] = (cnt_q[i] == last_q[i]);
        end
    end

    // clk_en is the third handshake term; it gates the register update below.
    assign hs       = valid_q & addr_ready;
    assign pass_end = &wrap;

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    logic carry;

    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        addr_d  = addr_q;
        valid_d = valid_q;
        done_d  = 1'b0;
        carry   = 1'b0;
        for (int i = 0; i < NDIM; i++) begin
            stride_d[i] = stride_q[i];
            last_d[i]   = last_q[i];
            cnt_d[i]    = cnt_q[i];
            off_d[i]    = off_q[i];
        end

        if (flush) begin
            // Abort wins over start and over a handshake in the same cycle.
            state_d = IDLE;
            valid_d = 1'b0;
            for (int i = 0; i < NDIM; i++) begin
                cnt_d[i] = CNT_ZERO;
                off_d[i] = ADDR_ZERO;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_d = RUN;
                        base_d  = starting_addr;
                        addr_d  = starting_addr;
                        valid_d = 1'b1;
                        for (int i = 0; i < NDIM; i++) begin
                            stride_d[i] = cfg_stride[i];
                            last_d[i]   = cfg_last[i];
                            cnt_d[i]    = CNT_ZERO;
                            off_d[i]    = ADDR_ZERO;
                        end
                    end
                end

                RUN: begin
                    if (hs) begin
                        if (pass_end) begin
                            done_d = 1'b1;
                            for (int i = 0; i < NDIM; i++) begin
                                cnt_d[i] = CNT_ZERO;
                                off_d[i] = ADDR_ZERO;
                            end
`ifdef DB_AGEN_CIRCULAR_EN
                            addr_d = base_q;
`else
                            valid_d = 1'b0;
                            state_d = IDLE;
`endif
                        end else begin
                            // Odometer: a wrapping digit clears and carries
                            // into the next one; the first non-wrapping digit
                            // absorbs the carry.
                            carry = 1'b1;
                            for (int i = 0; i < NDIM; i++) begin
                                if (carry) begin
                                    if (wrap[i]) begin
                                        cnt_d[i] = CNT_ZERO;
                                        off_d[i] = ADDR_ZERO;
                                    end else begin
                                        cnt_d[i] = cnt_q[i] + CNT_ONE;
                                        off_d[i] = off_q[i] + stride_q[i];
                                        carry    = 1'b0;
                                    end
                                end
                            end
                            addr_d = base_q + off_d[0] + off_d[1] + off_d[2];
                        end
                    end
                end

                default: begin
                    state_d = IDLE;
                    valid_d = 1'b0;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            base_q  <= ADDR_ZERO;
            addr_q  <= ADDR_ZERO;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            for (int i = 0; i < NDIM; i++) begin
                stride_q[i] <= ADDR_ZERO;
                last_q[i]   <= CNT_ZERO;
                cnt_q[i]    <= CNT_ZERO;
                off_q[i]    <= ADDR_ZERO;
            end
        end else if (clk_en) begin
            state_q <= state_d;
            base_q  <= base_d;
            addr_q  <= addr_d;
            valid_q <= valid_d;
            done_q  <= done_d;
            for (int i = 0; i < NDIM; i++) begin
                stride_q[i] <= stride_d[i];
                last_q[i]   <= last_d[i];
                cnt_q[i]    <= cnt_d[i];
                off_q[i]    <= off_d[i];
            end
        end
    end

    assign addr_out   = addr_q;
    assign addr_valid = valid_q;
    assign done       = done_q;
    assign busy       = (state_q == RUN);

endmodule

// File: tb/tb_db_read_addr_gen.sv
// -----------------------------------------------------------------------------
// tb_db_read_addr_gen
//
// Directed bench for db_read_addr_gen. Each test pushes its hand-derived
// address sequence into a queue before starting a pass; a monitor on the
// falling edge compares every presented address against the queue head, pops
// on each accepted handshake, and tracks when a done pulse is due.
// -----------------------------------------------------------------------------
module tb_db_read_addr_gen;

    logic        clk            = 1'b0;
    logic        reset          = 1'b1;
    logic        clk_en         = 1'b1;
    logic        flush          = 1'b0;
    logic        start          = 1'b0;
    logic [3:0]  dimensionality = 4'd0;
    logic [15:0] starting_addr  = 16'd0;
    logic [15:0] stride_0       = 16'd0;
    logic [15:0] stride_1       = 16'd0;
    logic [15:0] stride_2       = 16'd0;
    logic [31:0] range_0        = 32'd0;
    logic [31:0] range_1        = 32'd0;
    logic [31:0] range_2        = 32'd0;
    logic        addr_ready     = 1'b0;
    logic [15:0] addr_out;
    logic        addr_valid;
    logic        busy;
    logic        done;

    db_read_addr_gen dut (
        .clk            (clk),
        .reset          (reset),
        .clk_en         (clk_en),
        .flush          (flush),
        .start          (start),
        .dimensionality (dimensionality),
        .starting_addr  (starting_addr),
        .stride_0       (stride_0),
        .stride_1       (stride_1),
        .stride_2       (stride_2),
        .range_0        (range_0),
        .range_1        (range_1),
        .range_2        (range_2),
        .addr_out       (addr_out),
        .addr_valid     (addr_valid),
        .addr_ready     (addr_ready),
        .busy           (busy),
        .done           (done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] addr;
        logic        last;
    } exp_t;

    exp_t exp_q[$];
    logic exp_done = 1'b0;
    int   checks   = 0;
    int   failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic push(input logic [15:0] a, input logic l);
        exp_t e;
        e.addr = a;
        e.last = l;
        exp_q.push_back(e);
    endtask

    // n consecutive addresses from base; the final one closes the pass if
    // mark_last is set.
    task automatic push_seq(input logic [15:0] base, input int n, input logic mark_last);
        for (int k = 0; k < n; k++) begin
            push(base + 16'(k), mark_last && (k == n - 1));
        end
    endtask

    task automatic start_pass(input logic [3:0]  dim,
                              input logic [15:0] base,
                              input logic [15:0] s0,
                              input logic [15:0] s1,
                              input logic [15:0] s2,
                              input logic [31:0] r0,
                              input logic [31:0] r1,
                              input logic [31:0] r2);
        dimensionality = dim;
        starting_addr  = base;
        stride_0       = s0;
        stride_1       = s1;
        stride_2       = s2;
        range_0        = r0;
        range_1        = r1;
        range_2        = r2;
        start          = 1'b1;
        @(posedge clk);
        #1;
        start          = 1'b0;
    endtask

    // Counts cycles until done is seen; optionally drives addr_ready with the
    // repeating pattern 1,0,0,1.
    task automatic wait_done(input string name, input int max_cyc, input bit toggle, output int cyc);
        cyc = 0;
        for (int i = 0; i < max_cyc; i++) begin
            if (toggle) addr_ready = ((i % 4) == 0) || ((i % 4) == 3);
            @(posedge clk);
            #1;
            cyc++;
            if (done) return;
        end
        checks++;
        failures++;
        $display("FAIL %s: no done within %0d cycles", name, max_cyc);
    endtask

    task automatic wait_drain(input string name, input int max_cyc);
        for (int i = 0; i < max_cyc; i++) begin
            @(posedge clk);
            #1;
            if (exp_q.size() == 0) return;
        end
        checks++;
        failures++;
        $display("FAIL %s: %0d expected addresses still pending", name, exp_q.size());
    endtask

    // Monitor / scoreboard
    always @(negedge clk) begin
        exp_t e;
        logic hs_last;
        hs_last = 1'b0;
        if (!reset) begin
            exp_q.delete();
            exp_done = 1'b0;
        end else begin
            chk("done", 32'(done), 32'(exp_done));
            if (flush && clk_en) begin
                exp_q.delete();
                exp_done = 1'b0;
            end else begin
                if (addr_valid) begin
                    if (exp_q.size() == 0) begin
                        chk("valid_without_expected_addr", 32'(addr_valid), 32'd0);
                    end else begin
                        chk("addr_out", 32'(addr_out), 32'(exp_q[0].addr));
                        if (addr_ready && clk_en) begin
                            e       = exp_q.pop_front();
                            hs_last = e.last;
                        end
                    end
                end
                if (clk_en) exp_done = hs_last;
            end
        end
    end

    initial begin
        int cyc;

        #2 reset = 1'b0;
        #1;
        chk("rst_addr_out", 32'(addr_out), 32'd0);
        chk("rst_addr_valid", 32'(addr_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        #19 reset = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
            chk("idle_valid_after_reset", 32'(addr_valid), 32'd0);
            chk("idle_busy_after_reset", 32'(busy), 32'd0);
        end

`ifdef DB_AGEN_CIRCULAR_EN
        // Circular: 0,1,0,1 with done after each second handshake.
        addr_ready = 1'b1;
        push(16'd0, 1'b0); push(16'd1, 1'b1); push(16'd0, 1'b0); push(16'd1, 1'b1);
        start_pass(4'd1, 16'h0000, 16'd1, 16'd0, 16'd0, 32'd2, 32'd1, 32'd1);
        wait_drain("circ_drain", 20);
        chk("circ_busy_kept", 32'(busy), 32'd1);
        chk("circ_restart_valid", 32'(addr_valid), 32'd1);
        chk("circ_restart_addr", 32'(addr_out), 32'd0);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        chk("circ_flush_valid", 32'(addr_valid), 32'd0);
        chk("circ_flush_busy", 32'(busy), 32'd0);
`else
        // 3-D walk, strides 1/3/9 over 3x3x3: linear addresses 0..26.
        addr_ready = 1'b1;
        push_seq(16'h0000, 27, 1'b1);
        start_pass(4'd3, 16'h0000, 16'd1, 16'd3, 16'd9, 32'd3, 32'd3, 32'd3);
        chk("t1_busy_running", 32'(busy), 32'd1);
        wait_done("t1_done", 60, 1'b0, cyc);
        chk("t1_pass_cycles", 32'(cyc), 32'd27);
        chk("t1_busy_after", 32'(busy), 32'd0);
        chk("t1_valid_after", 32'(addr_valid), 32'd0);

        // 16-bit wrap of the address; unused dimension config ignored;
        // pending done held across clk_en=0.
        push(16'hFFFE, 1'b0); push(16'hFFFF, 1'b0); push(16'h0000, 1'b0); push(16'h0001, 1'b1);
        start_pass(4'd1, 16'hFFFE, 16'd1, 16'd5, 16'd5, 32'd4, 32'd7, 32'd7);
        wait_done("t2_done", 20, 1'b0, cyc);
        chk("t2_pass_cycles", 32'(cyc), 32'd4);
        clk_en = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
            chk("t2_done_held", 32'(done), 32'd1);
        end
        clk_en = 1'b1;
        @(posedge clk);
        #1;
        chk("t2_done_cleared", 32'(done), 32'd0);

        // Back-pressure 1,0,0,1: 0, 2, 16, 18 each held while not ready.
        push(16'd0, 1'b0); push(16'd2, 1'b0); push(16'd16, 1'b0); push(16'd18, 1'b1);
        start_pass(4'd2, 16'h0000, 16'd2, 16'd16, 16'd0, 32'd2, 32'd2, 32'd0);
        wait_done("t3_done", 40, 1'b1, cyc);
        chk("t3_pass_cycles", 32'(cyc), 32'd8);
        addr_ready = 1'b1;

        // range_1=0 acts as 1; start and config changes during RUN ignored.
        addr_ready = 1'b0;
        push(16'd0, 1'b0); push(16'd1, 1'b0); push(16'd2, 1'b1);
        start_pass(4'd2, 16'h0000, 16'd1, 16'h0040, 16'd0, 32'd3, 32'd0, 32'd0);
        starting_addr  = 16'h0500;
        stride_0       = 16'd7;
        dimensionality = 4'd1;
        range_0        = 32'd9;
        start          = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("t4_busy_running", 32'(busy), 32'd1);
        addr_ready = 1'b1;
        wait_done("t4_done", 20, 1'b0, cyc);
        chk("t4_pass_cycles", 32'(cyc), 32'd3);
        chk("t4_busy_after", 32'(busy), 32'd0);

        // dimensionality=7 clamps to 3; clk_en=0 freezes mid-pass.
        push(16'd0, 1'b0); push(16'd1, 1'b0); push(16'd10, 1'b0); push(16'd11, 1'b0);
        push(16'd100, 1'b0); push(16'd101, 1'b0); push(16'd110, 1'b0); push(16'd111, 1'b1);
        start_pass(4'd7, 16'h0000, 16'd1, 16'd10, 16'd100, 32'd2, 32'd2, 32'd2);
        @(posedge clk);
        #1;
        clk_en = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("t5_frozen_valid", 32'(addr_valid), 32'd1);
        clk_en = 1'b1;
        wait_done("t5_done", 30, 1'b0, cyc);
        chk("t5_pass_cycles", 32'(cyc), 32'd7);

        // dimensionality=0 behaves as 1.
        push(16'h0010, 1'b0); push(16'h0014, 1'b1);
        start_pass(4'd0, 16'h0010, 16'd4, 16'd1, 16'd1, 32'd2, 32'd5, 32'd5);
        wait_done("t6_done", 20, 1'b0, cyc);
        chk("t6_pass_cycles", 32'(cyc), 32'd2);

        // Flush after the 5th handshake; flush beats handshake and start.
        push_seq(16'h0100, 5, 1'b0);
        start_pass(4'd3, 16'h0100, 16'd1, 16'd3, 16'd9, 32'd3, 32'd3, 32'd3);
        wait_drain("t7_drain", 20);
        flush = 1'b1;
        @(posedge clk);
        #1;
        chk("t7_flush_valid", 32'(addr_valid), 32'd0);
        chk("t7_flush_busy", 32'(busy), 32'd0);
        start = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        start = 1'b0;
        chk("t7_flush_over_start", 32'(busy), 32'd0);
        push_seq(16'h0100, 27, 1'b1);
        start_pass(4'd3, 16'h0100, 16'd1, 16'd3, 16'd9, 32'd3, 32'd3, 32'd3);
        wait_done("t7_restart_done", 60, 1'b0, cyc);
        chk("t7_restart_cycles", 32'(cyc), 32'd27);

        // Asynchronous reset mid-pass discards the pass.
        push_seq(16'h0200, 27, 1'b1);
        start_pass(4'd3, 16'h0200, 16'd1, 16'd3, 16'd9, 32'd3, 32'd3, 32'd3);
        repeat (8) @(posedge clk);
        #3 reset = 1'b0;
        #1;
        chk("t8_rst_addr_out", 32'(addr_out), 32'd0);
        chk("t8_rst_valid", 32'(addr_valid), 32'd0);
        chk("t8_rst_busy", 32'(busy), 32'd0);
        chk("t8_rst_done", 32'(done), 32'd0);
        @(negedge clk);
        #2 reset = 1'b1;
        repeat (4) begin
            @(posedge clk);
            #1;
            chk("t8_post_rst_valid", 32'(addr_valid), 32'd0);
            chk("t8_post_rst_busy", 32'(busy), 32'd0);
        end
        push(16'h0030, 1'b0); push(16'h0033, 1'b1);
        start_pass(4'd1, 16'h0030, 16'd3, 16'd0, 16'd0, 32'd2, 32'd0, 32'd0);
        wait_done("t8_restart_done", 20, 1'b0, cyc);
        chk("t8_restart_cycles", 32'(cyc), 32'd2);
`endif

        repeat (3) @(posedge clk);
        #1;
        chk("queue_empty_at_end", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        failures++;
        $display("FAIL watchdog: simulation did not finish by t=%0t", $time);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/db_read_addr_gen.md
DB_READ_ADDR_GEN -- requirements
Module: db_read_addr_gen

Interface
REQ-001 SHALL have ports, one per line (name  direction  width  meaning):
  clk  in  1  single clock, rising edge
  reset  in  1  asynchronous, active-low reset
  clk_en  in  1  global enable; low freezes all state
  flush  in  1  synchronous abort to IDLE
  start  in  1  begin address sequence
  dimensionality  in  4  active loop dimensions
  starting_addr  in  16  base address
  stride_0, stride_1, stride_2  in  16 each  per-dimension address step
  range_0, range_1, range_2  in  32 each  per-dimension iteration count
  addr_out  out  16  read address to the double-buffer read port
  addr_valid  out  1  addr_out valid
  addr_ready  in  1  consumer accepts addr_out
  busy  out  1  sequence in progress
  done  out  1  one-cycle pulse at end of pass
REQ-002 SHALL accept a handshake only when addr_valid, addr_ready and clk_en are all 1 in the same cycle.

Function
REQ-003 SHALL implement the states IDLE and RUN; busy = (state == RUN).
REQ-004 IDLE: start=1 with clk_en=1 SHALL latch all configuration inputs and enter RUN, with addr_valid=1 and addr_out=starting_addr on the next cycle.
REQ-005 SHALL ignore configuration inputs after latching; changes during RUN SHALL have no effect.
REQ-006 SHALL ignore start while in RUN.
REQ-007 addr_out SHALL equal starting_addr + c0*stride_0 + c1*stride_1 + c2*stride_2, truncated mod 2^16; c0 is the innermost (fastest) counter.
REQ-008 On each handshake, SHALL increment c0; on c0 == r0-1, SHALL clear c0 and increment c1; the same cascade SHALL apply from c1 to c2.
REQ-009 Addresses SHALL be computed incrementally from registered per-dimension offsets, with no multipliers; the new address SHALL be valid the cycle after the handshake.
REQ-010 The effective range r_i SHALL be max(range_i, 1); dimensions at index >= dimensionality SHALL be treated as r=1, stride=0.
REQ-011 dimensionality=0 SHALL be treated as 1; values >3 SHALL be treated as 3.
REQ-012 A pass SHALL emit exactly r0*r1*r2 addresses in order, with no gaps while addr_ready=1 (one address per cycle).
REQ-013 While addr_valid=1 and addr_ready=0, addr_out SHALL be held stable.
REQ-014 Handshake of the final address SHALL pulse done=1 for the following cycle and deassert addr_valid in that same cycle; the state SHALL return to IDLE (non-circular build).
REQ-015 clk_en=0 SHALL hold all state and outputs, including a pending done, which SHALL then be presented for exactly one enabled cycle.
REQ-016 flush=1 with clk_en=1 SHALL, next cycle, clear the counters, set addr_valid=0, busy=0 and state=IDLE, with no done pulse; flush SHALL take priority over start and handshake.

Reset
REQ-017 reset=0 SHALL asynchronously force state=IDLE, all counters and offsets=0, addr_out=0, addr_valid=0, busy=0 and done=0.
REQ-018 Reset asserted mid-pass SHALL discard the pass; no done SHALL be produced after reset is released.
REQ-019 After reset is released, the block SHALL require a new start before any addr_valid.

Configuration
REQ-020 Macro DB_AGEN_CIRCULAR_EN: when defined, the final handshake of a pass SHALL pulse done, restart from starting_addr the next cycle and remain in RUN; only flush or reset SHALL exit.
REQ-021 Without DB_AGEN_CIRCULAR_EN, the block SHALL behave as REQ-014, with no circular logic synthesized.

Verification
REQ-022 dim=3, base=0, strides 1/3/9, ranges 3/3/3, addr_ready=1 -> addresses 0..26 on 27 consecutive cycles, done on the cycle after 26, then IDLE.
REQ-023 dim=1, base=0xFFFE, stride_0=1, range_0=4 -> FFFE, FFFF, 0000, 0001, then done.
REQ-024 dim=2, strides 2/16, ranges 2/2, addr_ready toggling 1,0,0,1,... -> 0, 2, 16, 18, each held stable while not ready; exactly one done.
REQ-025 range_1=0, dim=2, stride_0=1, range_0=3 -> 3 addresses (0, 1, 2), done; start pulsed during RUN -> ignored.
REQ-026 Flush after the 5th handshake of a 27-address pass -> addr_valid=0 next cycle, no done; a new start restarts at starting_addr. Reset mid-pass -> same outputs asynchronously.
REQ-027 With DB_AGEN_CIRCULAR_EN, ranges 2/1/1, dim=1 -> 0, 1, 0, 1, ... with done after each second handshake; busy stays 1 until flush.
